// File: rtl/sudoku_pkg.sv
// sudoku_pkg: shared constants and state encoding for the board streamer.
//   GRID_N / N_CELLS : board geometry (9x9 = 81 cells).
//   CELL_W           : width of one streamed cell word.
//   EMPTY_BIT        : bit of the cell word that flags an empty cell.
//   EMPTY_WORD       : cell word sent for an empty cell.
//   ST_*             : streamer FSM state encoding.
package sudoku_pkg;

    localparam int GRID_N    = 9;
    localparam int N_CELLS   = 81;
    localparam int CELL_W    = 11;
    localparam int EMPTY_BIT = 10;

    localparam logic [CELL_W-1:0] EMPTY_WORD = 11'h400;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_FIN    = 2'd2;

    typedef logic [3:0] digit_t;

    // A stored digit is 0 (empty) or 1..9; codes 10..15 never reach the board.
    function automatic logic digit_legal(input digit_t d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/sudoku_cell_encoder.sv
// sudoku_cell_encoder: combinational digit -> cell word map.
//   digit : 4-bit cell content, 0 = empty, 1..9 = digit.
//   word  : 11-bit cell word. Empty (and any out-of-range code) gives
//           EMPTY_WORD; digit d gives a one-hot [9:0] with bit d set.
module sudoku_cell_encoder
    import sudoku_pkg::*;
(
    input  logic [3:0]        digit,
    output logic [CELL_W-1:0] word
);

    always_comb begin
        word = EMPTY_WORD;
        if (digit != 4'd0 && digit_legal(digit)) begin
            // Bit 10 (empty flag) is 0 and bit 0 is never set for d >= 1.
            word = {1'b0, (10'd1 << digit)};
        end
    end

endmodule

// File: rtl/sudoku_board_streamer.sv
// sudoku_board_streamer: holds a 9x9 board and streams it to the solver.
//   clk, rst_n  : clock (rising edge) and asynchronous active-low reset.
//   clear       : empty every cell (IDLE only, wins over wr_en).
//   wr_en, wr_row, wr_col, wr_digit : single-cell write (IDLE only).
//   start       : begin streaming the 81 cells (IDLE only).
//   stall       : hold the stream for this beat.
//   reading     : data carries a cell word this cycle.
//   data        : cell word; holds its last value while reading is low.
//   busy        : high while streaming and during the closing cycle.
//   done        : one-cycle pulse after the last cell.
//   filled_cnt  : number of non-empty cells.
//   wr_err      : one-cycle pulse after a rejected write.
//
// Handshake: the receiver samples data on every cycle with reading high;
// there is no back-pressure from the receiver, only the local stall input.
// Cells go out column-major: beat k carries row k%9, column k/9, tracked
// with separate row/column counters.
module sudoku_board_streamer #(
    parameter int GAP    = 0,
    parameter int CELL_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [3:0]        wr_row,
    input  logic [3:0]        wr_col,
    input  logic [3:0]        wr_digit,
    input  logic              start,
    input  logic              stall,
    output logic              reading,
    output logic [CELL_W-1:0] data,
    output logic              busy,
    output logic              done,
    output logic [6:0]        filled_cnt,
    output logic              wr_err
);
    import sudoku_pkg::*;

    localparam int GAP_W = (GAP > 1) ? $clog2(GAP + 1) : 1;

    logic [1:0]       state;
    logic [3:0]       row_q;
    logic [3:0]       col_q;
    logic [GAP_W-1:0] gap_q;
    logic [3:0]       cells [N_CELLS];

    logic [6:0]        wr_idx;
    logic [6:0]        rd_idx;
    logic              wr_legal;
    logic [3:0]        old_digit;
    logic [3:0]        cur_digit;
    logic [CELL_W-1:0] cur_word;
    logic              last_cell;

    // Row-major storage index; wr_idx is only used once wr_legal holds.
    assign wr_idx   = {3'b000, wr_row} * 7'd9 + {3'b000, wr_col};
    assign rd_idx   = {3'b000, row_q} * 7'd9 + {3'b000, col_q};
    assign wr_legal = (wr_row <= 4'd8) && (wr_col <= 4'd8) && digit_legal(wr_digit);

    always_comb begin
        old_digit = 4'd0;
        if (wr_legal) begin
            old_digit = cells[wr_idx];
        end
    end

    assign cur_digit = cells[rd_idx];
    assign last_cell = (row_q == 4'd8) && (col_q == 4'd8);

    sudoku_cell_encoder u_enc (
        .digit (cur_digit),
        .word  (cur_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            row_q      <= 4'd0;
            col_q      <= 4'd0;
            gap_q      <= '0;
            reading    <= 1'b0;
            data       <= EMPTY_WORD;
            busy       <= 1'b0;
            done       <= 1'b0;
            filled_cnt <= 7'd0;
            wr_err     <= 1'b0;
            for (int i = 0; i < N_CELLS; i++) begin
                cells[i] <= 4'd0;
            end
        end else begin
            done   <= 1'b0;
            wr_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    reading <= 1'b0;
                    if (clear) begin
                        for (int i = 0; i < N_CELLS; i++) begin
                            cells[i] <= 4'd0;
                        end
                        filled_cnt <= 7'd0;
                    end else if (wr_en) begin
                        if (!wr_legal) begin
                            wr_err <= 1'b1;
                        end else begin
                            cells[wr_idx] <= wr_digit;
                            // Count only empty<->non-empty transitions.
                            if (old_digit == 4'd0 && wr_digit != 4'd0) begin
                                filled_cnt <= filled_cnt + 7'd1;
                            end else if (old_digit != 4'd0 && wr_digit == 4'd0) begin
                                filled_cnt <= filled_cnt - 7'd1;
                            end
                        end
                    end
                    // A same-cycle write lands on this edge, before the
                    // first cell is read on the next one.
                    if (start) begin
                        state <= ST_STREAM;
                        row_q <= 4'd0;
                        col_q <= 4'd0;
                        gap_q <= '0;
                        busy  <= 1'b1;
                    end
                end

                ST_STREAM: begin
                    if (wr_en) begin
                        wr_err <= 1'b1;
                    end
                    // Gap cycles take precedence; a stall during a gap costs nothing.
                    if (gap_q != '0) begin
                        reading <= 1'b0;
                        gap_q   <= gap_q - 1'b1;
                    end else if (stall) begin
                        reading <= 1'b0;
                    end else begin
                        reading <= 1'b1;
                        data    <= cur_word;
                        gap_q   <= GAP_W'(GAP);
                        if (last_cell) begin
                            state <= ST_FIN;
                        end else if (row_q == 4'd8) begin
                            row_q <= 4'd0;
                            col_q <= col_q + 4'd1;
                        end else begin
                            row_q <= row_q + 4'd1;
                        end
                    end
                end

                ST_FIN: begin
                    if (wr_en) begin
                        wr_err <= 1'b1;
                    end
                    reading <= 1'b0;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end

                default: begin
                    reading <= 1'b0;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
